// File: rtl/ipm_distributed_sdpram_prefetch_ctrl_if.sv
// Bundle of all non-clock signals between the prefetch FIFO controller, its
// user and the external distributed SDPRAM.
//   user write : wr_en, wr_data -> full, almost_full, wr_overflow
//   user read  : rd_en -> rd_data, empty, almost_empty, rd_underflow, level
//   RAM side   : ram_wr_en/addr/data, ram_rd_addr out; ram_rd_data in
// master = user + RAM model side, slave = controller.
interface ipm_distributed_sdpram_prefetch_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  wr_overflow;
  logic                  rd_underflow;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output wr_en, wr_data, rd_en, ram_rd_data,
    input  full, almost_full, rd_data, empty, almost_empty, level,
           wr_overflow, rd_underflow, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_addr
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_rd_data,
    output full, almost_full, rd_data, empty, almost_empty, level,
           wr_overflow, rd_underflow, ram_wr_en, ram_wr_addr, ram_wr_data,
           ram_rd_addr
  );
endinterface

// File: rtl/ipm_distributed_sdpram_prefetch_ctrl.sv
// First-word-fall-through FIFO controller wrapped around an external
// distributed SDPRAM. Owns both pointers, drives the RAM write port straight
// from the user write request and prefetches words from the RAM read port so
// the head word is on rd_data before rd_en.
// Ports:
//   clk  - single clock
//   rst  - synchronous reset, active high
//   bus  - slave side of ipm_distributed_sdpram_prefetch_ctrl_if (user
//          write/read handshake, status flags, RAM port signals)
// RAM_OUT_REG=0: RAM q is combinational, one output stage.
// RAM_OUT_REG=1: RAM q is registered, output stage + skid stage + in-flight bit.
module ipm_distributed_sdpram_prefetch_ctrl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 4,
  parameter int RAM_OUT_REG      = 0,
  parameter int ALMOST_FULL_NUM  = (2**ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic clk,
  input  logic rst,
  ipm_distributed_sdpram_prefetch_ctrl_if.slave bus
);
  localparam int                  DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, level_q, level_nxt;
  logic                  full_q, af_q, ae_q, ovf_q, unf_q;
  logic                  out_vld, skid_vld, inflight;
  logic [DATA_WIDTH-1:0] out_data, skid_data;

  logic       wr_acc, rd_acc, out_free, fetch, land_vld;
  logic [1:0] slots_after;

  always_comb begin
    // full is the registered flag, so a simultaneous pop never frees a slot
    // for the write in the same cycle.
    wr_acc    = bus.wr_en & ~full_q;
    rd_acc    = bus.rd_en & out_vld;
    out_free  = ~out_vld | rd_acc;
    level_nxt = level_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    // Held stages plus the word in flight, once this cycle's pop is gone.
    // Bounded by 2, and rd_acc implies out_vld, so no underflow.
    slots_after = 2'(out_vld) + 2'(skid_vld) + 2'(inflight) - 2'(rd_acc);
    fetch       = 1'b0;
    land_vld    = 1'b0;
    if (RAM_OUT_REG != 0) begin
      fetch    = (rd_ptr != wr_ptr) && (slots_after < 2'd2);
      land_vld = inflight;
    end else begin
      // Combinational RAM: the fetched word lands on the same edge.
      fetch    = (rd_ptr != wr_ptr) && out_free;
      land_vld = fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      inflight  <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)  rd_ptr <= rd_ptr + 1'b1;
      inflight <= (RAM_OUT_REG != 0) && fetch;
      level_q  <= level_nxt;
      full_q   <= level_nxt == DEPTH_L;
      af_q     <= level_nxt >= AF_L;
      ae_q     <= level_nxt <= AE_L;
      ovf_q    <= bus.wr_en & full_q;
      unf_q    <= bus.rd_en & ~out_vld;
      // Skid holds the older word, so it moves forward before the RAM word.
      if (out_free) begin
        if (skid_vld) begin
          out_data <= skid_data;
          out_vld  <= 1'b1;
          skid_vld <= land_vld;
          if (land_vld) skid_data <= bus.ram_rd_data;
        end else if (land_vld) begin
          out_data <= bus.ram_rd_data;
          out_vld  <= 1'b1;
        end else begin
          out_vld  <= 1'b0;
        end
      end else if (land_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= bus.ram_rd_data;
      end
    end
  end

  assign bus.ram_wr_en    = bus.wr_en & ~full_q & ~rst;
  assign bus.ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_wr_data  = bus.wr_data;
  assign bus.ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.rd_data      = out_data;
  assign bus.empty        = ~out_vld;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.wr_overflow  = ovf_q;
  assign bus.rd_underflow = unf_q;
endmodule

// File: doc/ipm_distributed_sdpram_prefetch_ctrl.md
Name: ipm_distributed_sdpram_prefetch_ctrl

Overview:
- Single-clock first-word-fall-through (prefetch) FIFO controller that sits on both ports of an external distributed SDPRAM.
- Owns the write pointer and drives the RAM write port from the user write interface.
- Owns the read pointer, fetches words from the RAM read port, and presents the head word on rd_data before rd_en is asserted.
- Supports RAM read latency 0 (combinational q) or 1 (registered q) through a parameter.

Parameters:
- ADDR_WIDTH, 4: RAM address width, range 4-10; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 4: data width, range 1-256.
- RAM_OUT_REG, 0: RAM read latency in cycles; 0 = combinational, 1 = registered. Must match the RAM's OUT_REG.
- ALMOST_FULL_NUM, DEPTH-2: almost_full asserts when level >= this value.
- ALMOST_EMPTY_NUM, 2: almost_empty asserts when level <= this value.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- rd_en  in  1  pop the head word.
- rd_data  out  DATA_WIDTH  head word; valid while empty=0.
- empty  out  1  no valid head word.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- level  out  ADDR_WIDTH+1  total words held (RAM plus prefetch stages).
- wr_overflow  out  1  one-cycle pulse: wr_en while full.
- rd_underflow  out  1  one-cycle pulse: rd_en while empty.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.

Behaviour:
- Interface is decided: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: level=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, overflow/underflow=0, all pointers 0, all prefetch stages invalid.
- Reset during operation discards all contents, including any in-flight fetch.
- ram_wr_en is 0 while rst=1.

Write path:
- Write is accepted when wr_en=1 and full=0.
- Acceptance is combinational: ram_wr_en = wr_en & ~full & ~rst, ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0], ram_wr_data = wr_data.
- wr_ptr is ADDR_WIDTH+1 bits and increments on each accepted write.
- wr_en while full: write dropped, wr_overflow pulses on the next cycle.

Level and flags:
- level increments on an accepted write and decrements on an accepted read; both in the same cycle leave it unchanged.
- full is evaluated before the read in the same cycle: wr_en+rd_en while full gives read accepted, write rejected.
- All flags are registered and consistent with level after each edge.

Prefetch path, RAM_OUT_REG=0:
- One output stage. ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0].
- The stage loads ram_rd_data and rd_ptr increments when rd_ptr != wr_ptr and (the stage is invalid or is popped this cycle).
- Latency: write accepted at edge T gives empty=0 after edge T+1.

Prefetch path, RAM_OUT_REG=1:
- Output stage plus one skid stage, with a one-bit in-flight flag.
- A fetch issues (rd_ptr++, in-flight set) when rd_ptr != wr_ptr and occupied slots + in-flight, after this cycle's pop, is < 2.
- The returning word lands in the output stage if it is free or popped this cycle, otherwise in the skid stage.
- Latency: write at edge T gives empty=0 after edge T+2.
- Sustained throughput is 1 word/cycle with rd_en held high.

Read:
- Read is accepted when rd_en=1 and empty=0.
- rd_data advances to the next word, or empty asserts, after the edge.
- rd_en while empty: no state change, rd_data holds, rd_underflow pulses.

Pointers and ordering:
- Pointers wrap modulo 2*DEPTH; the RAM index is the low ADDR_WIDTH bits.
- Data order is strictly FIFO across the wrap.

Test Plan:
- RAM_OUT_REG=0, AW=4, DW=8: reset, write 0x11 at edge 0 -> empty=0 and rd_data=0x11 after edge 1 with no rd_en; level=1.
- Write 0x00..0x0F with no reads -> full=1 and level=16 after the 16th write. A 17th write of 0xFF -> wr_overflow pulse, level stays 16. Reading 16 words returns 0x00..0x0F in order, then empty=1.
- At level=16, assert wr_en (0xEE) and rd_en together -> read accepted, write rejected, level=15, 0xEE never appears.
- RAM_OUT_REG=1: wr_en every cycle with data 0..39, rd_en held high from cycle 0 -> first word visible after edge 2, then one word per cycle with no gaps across the pointer wrap at 16 and 32; output is 0..39 in order.
- At empty=1, pulse rd_en -> rd_underflow=1 for one cycle, level=0, rd_data unchanged.
- RAM_OUT_REG=1 with level=7 and a fetch in flight: assert rst for one edge -> empty=1, level=0, rd_data=0. A subsequent write of 0xA5 is the first word read out.
